flush_unit: RTL and testbench

- Owns the flush side of the reorder-buffer-to-flush-unit interface.
- Accepts one flush request from the reorder buffer at retire, caused by a branch mispredict, an exception or a replay.
- Sequences recovery in fixed order: a one-cycle backend kill, then restore of the speculative rename map from the committed architectural map, then a fetch redirect handshake.
- Blocks further requests until recovery completes.

---
 rtl/flush_unit.sv | 134 +++++++++++++
 tb/tb_flush_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/flush_unit.sv
// Flush sequencer for the ROB-to-flush interface: it takes one flush request at retire, then
// runs kill, rename-map restore and fetch redirect in that order.
module flush_unit #(
  parameter int unsigned     XLEN          = 32,
  parameter int unsigned     NUM_ARCH_REGS = 32,
  parameter int unsigned     ARCH_IDX_W    = 5,
  parameter int unsigned     PHYS_IDX_W    = 6,
  parameter int unsigned     ROB_IDX_W     = 5,
  parameter int unsigned     RESTORE_WIDTH = 4,
  parameter logic [XLEN-1:0] TRAP_VECTOR   = 32'h0000_0100
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush_req_valid,
  output logic                              flush_req_ready,
  input  logic [1:0]                        flush_req_cause,
  input  logic [XLEN-1:0]                   flush_req_pc,
  input  logic [ROB_IDX_W-1:0]              flush_req_rob_idx,
  output logic                              flush_o,
  output logic                              freelist_restore_o,
  output logic [RESTORE_WIDTH*ARCH_IDX_W-1:0] amt_rd_idx,
  input  logic [RESTORE_WIDTH*PHYS_IDX_W-1:0] amt_rd_data,
  output logic [RESTORE_WIDTH-1:0]          rat_wr_en,
  output logic [RESTORE_WIDTH*ARCH_IDX_W-1:0] rat_wr_idx,
  output logic [RESTORE_WIDTH*PHYS_IDX_W-1:0] rat_wr_data,
  output logic                              redirect_valid,
  input  logic                              redirect_ready,
  output logic [XLEN-1:0]                   redirect_pc,
  output logic [1:0]                        flush_cause_o,
  output logic                              busy,
  output logic [15:0]                       flush_count
);

  localparam int unsigned NumGroups = NUM_ARCH_REGS / RESTORE_WIDTH;
  localparam int unsigned CntW      = (NumGroups > 1) ? $clog2(NumGroups) : 1;
  localparam logic [1:0]  CauseExc  = 2'b01;

  typedef enum logic [1:0] {StIdle, StKill, StRestore, StRedirect} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [1:0]           cause_q;
  logic [XLEN-1:0]      pc_q;
  logic [ROB_IDX_W-1:0] rob_idx_q;
  logic [15:0]          flush_count_q;
  logic                 accept;

  assign flush_req_ready = (state_q == StIdle);
  assign accept          = flush_req_valid && flush_req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      cause_q       <= '0;
      pc_q          <= '0;
      rob_idx_q     <= '0;
      flush_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        cause_q   <= flush_req_cause;
        pc_q      <= flush_req_pc;
        rob_idx_q <= flush_req_rob_idx;
        if (flush_count_q != 16'hFFFF) flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StKill;
      end
      StKill: begin
        cnt_d   = '0;
        state_d = StRestore;
      end
      StRestore: begin
        if (cnt_q == CntW'(NumGroups - 1)) begin
          cnt_d   = '0;
          state_d = StRedirect;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRedirect: begin
        if (redirect_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Lane k of group g restores architectural register g*RESTORE_WIDTH+k.
  always_comb begin
    amt_rd_idx = '0;
    if (state_q == StRestore) begin
      for (int k = 0; k < int'(RESTORE_WIDTH); k++) begin
        amt_rd_idx[k*ARCH_IDX_W +: ARCH_IDX_W] =
          ARCH_IDX_W'(int'(cnt_q) * int'(RESTORE_WIDTH) + k);
      end
    end
  end

  always_comb begin
    rat_wr_en   = '0;
    rat_wr_idx  = '0;
    rat_wr_data = '0;
    if (state_q == StRestore) begin
      rat_wr_en   = '1;
      rat_wr_idx  = amt_rd_idx;
      rat_wr_data = amt_rd_data;
    end
  end

  always_comb begin
    redirect_pc = '0;
    if (state_q == StRedirect) begin
      // Reserved cause 11 falls through to the latched PC like a mispredict.
      redirect_pc = (cause_q == CauseExc) ? TRAP_VECTOR : pc_q;
    end
  end

  assign flush_o            = (state_q == StKill);
  assign freelist_restore_o = (state_q == StKill);
  assign redirect_valid     = (state_q == StRedirect);
  assign flush_cause_o      = cause_q;
  assign busy               = (state_q != StIdle);
  assign flush_count        = flush_count_q;

endmodule

// File: tb/tb_flush_unit.sv
// Directed bench for flush_unit: a combinational committed-map model returns idx+32 per lane.
module tb_flush_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_req_valid;
  logic        flush_req_ready;
  logic [1:0]  flush_req_cause;
  logic [31:0] flush_req_pc;
  logic [4:0]  flush_req_rob_idx;
  logic        flush_o;
  logic        freelist_restore_o;
  logic [19:0] amt_rd_idx;
  logic [23:0] amt_rd_data;
  logic [3:0]  rat_wr_en;
  logic [19:0] rat_wr_idx;
  logic [23:0] rat_wr_data;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic [1:0]  flush_cause_o;
  logic        busy;
  logic [15:0] flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  flush_unit dut (
    .clk                (clk),
    .rst                (rst),
    .flush_req_valid    (flush_req_valid),
    .flush_req_ready    (flush_req_ready),
    .flush_req_cause    (flush_req_cause),
    .flush_req_pc       (flush_req_pc),
    .flush_req_rob_idx  (flush_req_rob_idx),
    .flush_o            (flush_o),
    .freelist_restore_o (freelist_restore_o),
    .amt_rd_idx         (amt_rd_idx),
    .amt_rd_data        (amt_rd_data),
    .rat_wr_en          (rat_wr_en),
    .rat_wr_idx         (rat_wr_idx),
    .rat_wr_data        (rat_wr_data),
    .redirect_valid     (redirect_valid),
    .redirect_ready     (redirect_ready),
    .redirect_pc        (redirect_pc),
    .flush_cause_o      (flush_cause_o),
    .busy               (busy),
    .flush_count        (flush_count)
  );

  // Committed map: entry i holds physical tag i+32.
  always_comb begin
    amt_rd_data = '0;
    for (int k = 0; k < 4; k++) begin
      amt_rd_data[k*6 +: 6] = 6'(amt_rd_idx[k*5 +: 5]) + 6'd32;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_restore_beats(input logic [1:0] exp_cause);
    for (int b = 0; b < 8; b++) begin
      step();
      check("rst_wr_en", 32'(rat_wr_en), 32'hF);
      check("rst_flush_low", 32'(flush_o), 32'd0);
      check("rst_redir_low", 32'(redirect_valid), 32'd0);
      check("rst_cause", 32'(flush_cause_o), 32'(exp_cause));
      for (int k = 0; k < 4; k++) begin
        check("rst_idx", 32'(rat_wr_idx[k*5 +: 5]), 32'(b*4 + k));
        check("rst_data", 32'(rat_wr_data[k*6 +: 6]), 32'(b*4 + k + 32));
      end
    end
  endtask

  task automatic do_flush(input logic [1:0] cause, input logic [31:0] pc,
                          input logic [31:0] exp_pc, input logic [15:0] exp_cnt);
    flush_req_valid   = 1'b1;
    flush_req_cause   = cause;
    flush_req_pc      = pc;
    flush_req_rob_idx = 5'd7;
    redirect_ready    = 1'b1;
    check("ready_before", 32'(flush_req_ready), 32'd1);
    step();
    flush_req_valid = 1'b0;
    check("kill_flush", 32'(flush_o), 32'd1);
    check("kill_freelist", 32'(freelist_restore_o), 32'd1);
    check("kill_ready", 32'(flush_req_ready), 32'd0);
    check("kill_busy", 32'(busy), 32'd1);
    check("kill_count", 32'(flush_count), 32'(exp_cnt));
    check("kill_cause", 32'(flush_cause_o), 32'(cause));
    check("kill_wr_en", 32'(rat_wr_en), 32'd0);
    check_restore_beats(cause);
    step();
    check("redir_valid", 32'(redirect_valid), 32'd1);
    check("redir_pc", redirect_pc, exp_pc);
    step();
    check("post_redir_valid", 32'(redirect_valid), 32'd0);
    check("post_ready", 32'(flush_req_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst               = 1'b0;
    flush_req_valid   = 1'b0;
    flush_req_cause   = 2'b00;
    flush_req_pc      = '0;
    flush_req_rob_idx = '0;
    redirect_ready    = 1'b0;
    #3;
    check("reset_ready", 32'(flush_req_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_count", 32'(flush_count), 32'd0);
    check("reset_flush", 32'(flush_o), 32'd0);
    check("reset_redir", 32'(redirect_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Mispredict with redirect_ready already high.
    do_flush(2'b00, 32'h0000_2040, 32'h0000_2040, 16'd1);

    // Exception under redirect backpressure, with a replay request held by the ROB.
    flush_req_valid = 1'b1;
    flush_req_cause = 2'b01;
    flush_req_pc    = 32'h0000_3000;
    redirect_ready  = 1'b0;
    step();
    flush_req_cause = 2'b10;
    flush_req_pc    = 32'h0000_4440;
    check("exc_kill", 32'(flush_o), 32'd1);
    check("exc_cause", 32'(flush_cause_o), 32'd1);
    check("exc_count", 32'(flush_count), 32'd2);
    check_restore_beats(2'b01);
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(redirect_valid), 32'd1);
      check("bp_pc", redirect_pc, 32'h0000_0100);
      check("bp_ready_low", 32'(flush_req_ready), 32'd0);
      check("bp_cause", 32'(flush_cause_o), 32'd1);
      check("bp_count", 32'(flush_count), 32'd2);
      if (i < 4) step();
    end
    redirect_ready = 1'b1;
    step();
    check("hs_idle_ready", 32'(flush_req_ready), 32'd1);
    check("hs_redir_low", 32'(redirect_valid), 32'd0);
    check("hs_count", 32'(flush_count), 32'd2);
    step();
    flush_req_valid = 1'b0;
    check("held_kill", 32'(flush_o), 32'd1);
    check("held_cause", 32'(flush_cause_o), 32'd2);
    check("held_count", 32'(flush_count), 32'd3);
    // redirect_ready stays high through KILL/RESTORE and must not short-cut the sequence.
    check_restore_beats(2'b10);
    step();
    check("replay_valid", 32'(redirect_valid), 32'd1);
    check("replay_pc", redirect_pc, 32'h0000_4440);
    step();
    check("replay_done", 32'(flush_req_ready), 32'd1);

    // Reserved cause redirects to the latched PC.
    do_flush(2'b11, 32'h0000_5550, 32'h0000_5550, 16'd4);

    // Asynchronous reset while the restore counter is 3.
    flush_req_valid = 1'b1;
    flush_req_cause = 2'b00;
    flush_req_pc    = 32'h0000_6000;
    step();
    flush_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("mid_idx", 32'(amt_rd_idx[4:0]), 32'd12);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(flush_req_ready), 32'd1);
    check("arst_wr_en", 32'(rat_wr_en), 32'd0);
    check("arst_wr_idx", 32'(rat_wr_idx), 32'd0);
    check("arst_amt_idx", 32'(amt_rd_idx), 32'd0);
    check("arst_redir", 32'(redirect_valid), 32'd0);
    check("arst_count", 32'(flush_count), 32'd0);
    check("arst_cause", 32'(flush_cause_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("rel_ready", 32'(flush_req_ready), 32'd1);
    check("rel_busy", 32'(busy), 32'd0);

    // Preload the counter near saturation instead of issuing 65533 flushes.
    @(negedge clk);
    dut.flush_count_q = 16'hFFFD;
    step();
    do_flush(2'b00, 32'h0000_0010, 32'h0000_0010, 16'hFFFE);
    do_flush(2'b00, 32'h0000_0020, 32'h0000_0020, 16'hFFFF);
    do_flush(2'b00, 32'h0000_0030, 32'h0000_0030, 16'hFFFF);
    check("sat_final", 32'(flush_count), 32'h0000_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
